// File: rtl/inst_enc_loader.sv
// inst_enc_loader: packs op/rd/rs/rt fields into 8-bit instruction words and
// writes them sequentially into instruction memory from address 0, reporting
// completion and overflow.
// DEPTH must be a power of two (>= 2) and AW must equal log2(DEPTH).
module inst_enc_loader #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [1:0]    rd,
    input  logic [1:0]    rs,
    input  logic [1:0]    rt,
    input  logic          last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic [AW:0]   count,
    output logic          done,
    output logic          overflow
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] wp;
    logic          xfer;

    // Ready only while loading; a start in the same cycle blocks the transfer
    assign in_ready = (state == S_LOAD) && !start;
    assign xfer     = in_valid && in_ready;

    // Session FSM, write pointer and registered memory-write outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wp        <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state    <= S_LOAD;
                wp       <= '0;
                count    <= '0;
                done     <= 1'b0;
                overflow <= 1'b0;
            end else if (xfer) begin
                mem_we    <= 1'b1;
                mem_addr  <= wp;
                mem_wdata <= {op, rd, rs, rt};
                count     <= count + 1'b1;
                wp        <= wp + 1'b1;
                if (last) begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    overflow <= 1'b0;
                end else if (wp == LAST_ADDR) begin
                    // Memory full without a final instruction: stop, never wrap
                    state    <= S_DONE;
                    done     <= 1'b1;
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
